// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_arbiter
//  Purpose  : Time-shares one combinational ALU between two requesters.
//             Port 0 is the fetch/execute path, port 1 the address/aux path.
//             A request is granted round-robin, its operands are registered
//             onto the ALU and held for EXEC_CYCLES cycles, then C/D/flags
//             are captured and returned over a valid/ready response.
//             The architectural flag register (psr_flags) is refreshed at
//             every capture.
//  Ports    : clk, reset                   - clock, synchronous active-high reset
//             req_valid/ready/op/a/b _0/_1 - request handshakes and operands
//             rsp_valid/ready _0/_1        - per-port response handshakes
//             rsp_c, rsp_d, rsp_flags      - captured result, shared by ports
//             psr_flags                    - architectural {Low, Negative, Zero}
//             alu_a, alu_b, alu_op         - registered ALU inputs
//             alu_c, alu_d, alu_low/neg/zero - ALU results
//             busy                         - high whenever not idle
//  Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int WIDTH       = 16,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [3:0]       req_op_0,
    input  logic [3:0]       req_op_1,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [WIDTH-1:0] req_b_1,
    output logic             rsp_valid_0,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_0,
    input  logic             rsp_ready_1,
    output logic [WIDTH-1:0] rsp_c,
    output logic [WIDTH-1:0] rsp_d,
    output logic [2:0]       rsp_flags,
    output logic [2:0]       psr_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_c,
    input  logic [WIDTH-1:0] alu_d,
    input  logic             alu_low,
    input  logic             alu_neg,
    input  logic             alu_zero,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Counter is loaded with EXEC_CYCLES-1 and capture happens when it is 0,
    // so the operands sit on the ALU for exactly EXEC_CYCLES cycles.
    localparam logic [3:0] C_CNT_LOAD = 4'(EXEC_CYCLES - 1);

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       r_port;        // port owning the op in flight
    logic       r_last_grant;  // port served most recently (1 after reset)

    logic w_idle;
    logic w_grant_0;
    logic w_grant_1;
    logic w_rsp_ack;

    assign w_idle = (r_state == S_IDLE);

    // On a tie the port that was not served last wins.
    assign w_grant_0 = req_valid_0 && (!req_valid_1 || r_last_grant);
    assign w_grant_1 = req_valid_1 && (!req_valid_0 || !r_last_grant);

    assign req_ready_0 = w_idle && w_grant_0;
    assign req_ready_1 = w_idle && w_grant_1;

    assign rsp_valid_0 = (r_state == S_RESP) && !r_port;
    assign rsp_valid_1 = (r_state == S_RESP) &&  r_port;

    // Only the owning port's ready can complete the response.
    assign w_rsp_ack = r_port ? rsp_ready_1 : rsp_ready_0;

    assign busy = !w_idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_port       <= 1'b0;
            r_last_grant <= 1'b1;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= 4'd0;
            rsp_c        <= '0;
            rsp_d        <= '0;
            rsp_flags    <= 3'd0;
            psr_flags    <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_ready_0 || req_ready_1) begin
                        alu_op  <= req_ready_1 ? req_op_1 : req_op_0;
                        alu_a   <= req_ready_1 ? req_a_1  : req_a_0;
                        alu_b   <= req_ready_1 ? req_b_1  : req_b_0;
                        r_port  <= req_ready_1;
                        r_cnt   <= C_CNT_LOAD;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        rsp_c     <= alu_c;
                        rsp_d     <= alu_d;
                        rsp_flags <= {alu_low, alu_neg, alu_zero};
                        psr_flags <= {alu_low, alu_neg, alu_zero};
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_rsp_ack) begin
                        r_last_grant <= r_port;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_share_arbiter
//  Purpose  : Self-checking bench for alu_share_arbiter. Two instances are
//             built: index 0 with EXEC_CYCLES=1 and index 1 with
//             EXEC_CYCLES=3. A small ALU fixture closes the ALU loop with
//             opcodes ADD=0, SUB=1, MUL=2; other opcodes return a^b^op.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int W = 16;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset       [2];
    logic         req_valid_0 [2];
    logic         req_valid_1 [2];
    logic         req_ready_0 [2];
    logic         req_ready_1 [2];
    logic [3:0]   req_op_0    [2];
    logic [3:0]   req_op_1    [2];
    logic [W-1:0] req_a_0     [2];
    logic [W-1:0] req_a_1     [2];
    logic [W-1:0] req_b_0     [2];
    logic [W-1:0] req_b_1     [2];
    logic         rsp_valid_0 [2];
    logic         rsp_valid_1 [2];
    logic         rsp_ready_0 [2];
    logic         rsp_ready_1 [2];
    logic [W-1:0] rsp_c       [2];
    logic [W-1:0] rsp_d       [2];
    logic [2:0]   rsp_flags   [2];
    logic [2:0]   psr_flags   [2];
    logic [W-1:0] alu_a       [2];
    logic [W-1:0] alu_b       [2];
    logic [3:0]   alu_op      [2];
    logic [W-1:0] alu_c       [2];
    logic [W-1:0] alu_d       [2];
    logic         alu_low     [2];
    logic         alu_neg     [2];
    logic         alu_zero    [2];
    logic         busy        [2];

    int errors = 0;
    int checks = 0;

    // Reference ALU: returns {d, c, low, neg, zero}.
    function automatic logic [34:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [31:0]  p;
        logic [W-1:0] c;
        logic [W-1:0] d;
        c = '0;
        d = '0;
        p = '0;
        case (op)
            OP_ADD:  c = a + b;
            OP_SUB:  c = a - b;
            OP_MUL:  begin p = {16'h0, a} * {16'h0, b}; c = p[15:0]; d = p[31:16]; end
            default: c = a ^ b ^ {12'h0, op};
        endcase
        return {d, c, (a < b), c[W-1], (c == '0)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_share_arbiter #(.WIDTH(W), .EXEC_CYCLES((g == 0) ? 1 : 3)) u_dut (
            .clk(clk), .reset(reset[g]),
            .req_valid_0(req_valid_0[g]), .req_valid_1(req_valid_1[g]),
            .req_ready_0(req_ready_0[g]), .req_ready_1(req_ready_1[g]),
            .req_op_0(req_op_0[g]), .req_op_1(req_op_1[g]),
            .req_a_0(req_a_0[g]), .req_a_1(req_a_1[g]),
            .req_b_0(req_b_0[g]), .req_b_1(req_b_1[g]),
            .rsp_valid_0(rsp_valid_0[g]), .rsp_valid_1(rsp_valid_1[g]),
            .rsp_ready_0(rsp_ready_0[g]), .rsp_ready_1(rsp_ready_1[g]),
            .rsp_c(rsp_c[g]), .rsp_d(rsp_d[g]), .rsp_flags(rsp_flags[g]),
            .psr_flags(psr_flags[g]),
            .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_op(alu_op[g]),
            .alu_c(alu_c[g]), .alu_d(alu_d[g]),
            .alu_low(alu_low[g]), .alu_neg(alu_neg[g]), .alu_zero(alu_zero[g]),
            .busy(busy[g])
        );
        assign {alu_d[g], alu_c[g], alu_low[g], alu_neg[g], alu_zero[g]} =
            alu_fn(alu_op[g], alu_a[g], alu_b[g]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int k, input int p, input logic v, input logic [3:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        if (p == 0) begin
            req_valid_0[k] = v; req_op_0[k] = op; req_a_0[k] = a; req_b_0[k] = b;
        end else begin
            req_valid_1[k] = v; req_op_1[k] = op; req_a_1[k] = a; req_b_1[k] = b;
        end
    endtask

    task automatic clear_inputs(input int k);
        drive_req(k, 0, 1'b0, 4'd0, '0, '0);
        drive_req(k, 1, 1'b0, 4'd0, '0, '0);
        rsp_ready_0[k] = 1'b0;
        rsp_ready_1[k] = 1'b0;
    endtask

    task automatic do_reset(input int k);
        clear_inputs(k);
        reset[k] = 1'b1;
        tick();
        tick();
        reset[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int k, input int p, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((p == 0) ? rsp_valid_0[k] : rsp_valid_1[k]) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            clear_inputs(k);
            reset[k] = 1'b1;
            tick();
            tick();
            checks++;
            if ({alu_a[k], alu_b[k], alu_op[k], rsp_c[k], rsp_d[k], rsp_flags[k], psr_flags[k]} !== '0) begin
                errors++;
                $display("FAIL reset_regs[%0d]: got a=%h b=%h op=%h c=%h d=%h f=%b psr=%b, expected all 0",
                         k, alu_a[k], alu_b[k], alu_op[k], rsp_c[k], rsp_d[k], rsp_flags[k], psr_flags[k]);
            end
            checks++;
            if ({rsp_valid_0[k], rsp_valid_1[k], busy[k], req_ready_0[k], req_ready_1[k]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: got rv0=%b rv1=%b busy=%b rq0=%b rq1=%b, expected all 0",
                         k, rsp_valid_0[k], rsp_valid_1[k], busy[k], req_ready_0[k], req_ready_1[k]);
            end
            reset[k] = 1'b0;
            drive_req(k, 0, 1'b1, OP_ADD, 16'd1, 16'd1);
            drive_req(k, 1, 1'b1, OP_ADD, 16'd2, 16'd2);
            #1;
            checks++;
            if ({req_ready_0[k], req_ready_1[k]} !== 2'b10) begin
                errors++;
                $display("FAIL reset_first_tie[%0d]: got ready0/1=%b%b, expected 10", k, req_ready_0[k], req_ready_1[k]);
            end
            clear_inputs(k);
        end
    endtask

    task automatic test_single();
        do_reset(0);
        drive_req(0, 0, 1'b1, OP_SUB, 16'd5, 16'd5);
        #1;
        checks++;
        if ({req_ready_0[0], req_ready_1[0]} !== 2'b10) begin
            errors++;
            $display("FAIL single_ready: got %b%b, expected 10", req_ready_0[0], req_ready_1[0]);
        end
        tick();
        drive_req(0, 0, 1'b0, 4'd0, '0, '0);
        checks++;
        if ({busy[0], rsp_valid_0[0], alu_op[0], alu_a[0], alu_b[0]} !== {1'b1, 1'b0, OP_SUB, 16'd5, 16'd5}) begin
            errors++;
            $display("FAIL single_exec: got busy=%b rv0=%b op=%h a=%h b=%h, expected 1 0 1 0005 0005",
                     busy[0], rsp_valid_0[0], alu_op[0], alu_a[0], alu_b[0]);
        end
        tick();
        checks++;
        if ({rsp_valid_0[0], rsp_valid_1[0], busy[0]} !== 3'b101) begin
            errors++;
            $display("FAIL single_rsp_valid: got rv0=%b rv1=%b busy=%b, expected 1 0 1",
                     rsp_valid_0[0], rsp_valid_1[0], busy[0]);
        end
        checks++;
        if ({rsp_c[0], rsp_d[0], rsp_flags[0], psr_flags[0]} !== {16'h0000, 16'h0000, 3'b001, 3'b001}) begin
            errors++;
            $display("FAIL single_result: got c=%h d=%h f=%b psr=%b, expected 0000 0000 001 001",
                     rsp_c[0], rsp_d[0], rsp_flags[0], psr_flags[0]);
        end
        rsp_ready_0[0] = 1'b1;
        tick();
        rsp_ready_0[0] = 1'b0;
        checks++;
        if ({busy[0], rsp_valid_0[0], psr_flags[0]} !== {1'b0, 1'b0, 3'b001}) begin
            errors++;
            $display("FAIL single_done: got busy=%b rv0=%b psr=%b, expected 0 0 001",
                     busy[0], rsp_valid_0[0], psr_flags[0]);
        end
    endtask

    task automatic test_tie();
        int grants[$];
        int rports[$];
        logic [W-1:0] rc[$];
        logic [2:0] rf[$];
        do_reset(0);
        drive_req(0, 0, 1'b1, OP_ADD, 16'd1, 16'd2);
        drive_req(0, 1, 1'b1, OP_ADD, 16'h7FFF, 16'd1);
        rsp_ready_0[0] = 1'b1;
        rsp_ready_1[0] = 1'b1;
        for (int c = 0; c < 30 && grants.size() < 3; c++) begin
            #1;
            if (req_ready_0[0] && req_ready_1[0]) begin
                errors++;
                $display("FAIL tie_onehot: both req_ready high, expected at most one");
            end
            if (req_ready_0[0]) grants.push_back(0);
            if (req_ready_1[0]) grants.push_back(1);
            if (rsp_valid_0[0]) begin rports.push_back(0); rc.push_back(rsp_c[0]); rf.push_back(rsp_flags[0]); end
            if (rsp_valid_1[0]) begin rports.push_back(1); rc.push_back(rsp_c[0]); rf.push_back(rsp_flags[0]); end
            if (grants.size() < 3) tick();
        end
        clear_inputs(0);
        checks++;
        if (grants.size() != 3 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0) begin
            errors++;
            $display("FAIL tie_order: got %0d grants %p, expected 0,1,0", grants.size(), grants);
        end
        checks++;
        if (rports.size() < 2) begin
            errors++;
            $display("FAIL tie_rsp_count: got %0d responses, expected 2", rports.size());
        end else begin
            checks++;
            if (rports[0] != 0 || rc[0] !== 16'h0003) begin
                errors++;
                $display("FAIL tie_rsp0: got port=%0d c=%h, expected port 0 c=0003", rports[0], rc[0]);
            end
            checks++;
            if (rports[1] != 1 || rc[1] !== 16'h8000 || rf[1][1] !== 1'b1) begin
                errors++;
                $display("FAIL tie_rsp1: got port=%0d c=%h neg=%b, expected port 1 c=8000 neg=1",
                         rports[1], rc[1], rf[1][1]);
            end
        end
    endtask

    task automatic test_mul();
        bit ok;
        do_reset(0);
        drive_req(0, 1, 1'b1, OP_MUL, 16'h1234, 16'h0100);
        tick();
        drive_req(0, 1, 1'b0, 4'd0, '0, '0);
        wait_rsp(0, 1, 10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mul_timeout: got no rsp_valid_1, expected within 10 cycles");
        end
        checks++;
        if ({rsp_c[0], rsp_d[0], rsp_valid_0[0], rsp_valid_1[0]} !== {16'h3400, 16'h0012, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mul_result: got c=%h d=%h rv0=%b rv1=%b, expected 3400 0012 0 1",
                     rsp_c[0], rsp_d[0], rsp_valid_0[0], rsp_valid_1[0]);
        end
        rsp_ready_1[0] = 1'b1;
        tick();
        rsp_ready_1[0] = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset(0);
        drive_req(0, 0, 1'b1, OP_ADD, 16'h0010, 16'h0020);
        drive_req(0, 1, 1'b1, OP_ADD, 16'h0001, 16'h0001);
        tick();
        drive_req(0, 0, 1'b0, 4'd0, '0, '0);
        wait_rsp(0, 0, 10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_timeout: got no rsp_valid_0, expected within 10 cycles");
        end
        rsp_ready_1[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({rsp_valid_0[0], rsp_valid_1[0], req_ready_0[0], req_ready_1[0], rsp_c[0], rsp_flags[0]}
                !== {4'b1000, 16'h0030, 3'b100}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got rv=%b%b rq=%b%b c=%h f=%b, expected rv=10 rq=00 c=0030 f=100",
                         i, rsp_valid_0[0], rsp_valid_1[0], req_ready_0[0], req_ready_1[0], rsp_c[0], rsp_flags[0]);
            end
            tick();
        end
        rsp_ready_1[0] = 1'b0;
        rsp_ready_0[0] = 1'b1;
        tick();
        rsp_ready_0[0] = 1'b0;
        #1;
        checks++;
        if ({req_ready_0[0], req_ready_1[0]} !== 2'b01) begin
            errors++;
            $display("FAIL bp_next_grant: got ready0/1=%b%b, expected 01", req_ready_0[0], req_ready_1[0]);
        end
        tick();
        drive_req(0, 1, 1'b0, 4'd0, '0, '0);
        wait_rsp(0, 1, 10, ok);
        checks++;
        if (!ok || rsp_c[0] !== 16'h0002) begin
            errors++;
            $display("FAIL bp_port1_rsp: got ok=%b c=%h, expected 1 0002", ok, rsp_c[0]);
        end
        rsp_ready_1[0] = 1'b1;
        tick();
        rsp_ready_1[0] = 1'b0;
    endtask

    task automatic test_exec3();
        do_reset(1);
        drive_req(1, 0, 1'b1, OP_ADD, 16'h1111, 16'h2222);
        tick();
        drive_req(1, 0, 1'b0, OP_SUB, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({alu_op[1], alu_a[1], alu_b[1], rsp_valid_0[1]} !== {OP_ADD, 16'h1111, 16'h2222, 1'b0}) begin
                errors++;
                $display("FAIL exec3_hold[%0d]: got op=%h a=%h b=%h rv0=%b, expected 0 1111 2222 0",
                         i, alu_op[1], alu_a[1], alu_b[1], rsp_valid_0[1]);
            end
            tick();
        end
        checks++;
        if ({rsp_valid_0[1], rsp_c[1]} !== {1'b1, 16'h3333}) begin
            errors++;
            $display("FAIL exec3_rsp: got rv0=%b c=%h, expected 1 3333", rsp_valid_0[1], rsp_c[1]);
        end
        rsp_ready_0[1] = 1'b1;
        tick();
        rsp_ready_0[1] = 1'b0;
    endtask

    task automatic test_reset_exec();
        do_reset(0);
        drive_req(0, 0, 1'b1, OP_SUB, 16'd5, 16'd5);
        tick();
        reset[0] = 1'b1;
        drive_req(0, 0, 1'b1, OP_ADD, 16'd1, 16'd1);
        drive_req(0, 1, 1'b1, OP_ADD, 16'd2, 16'd2);
        rsp_ready_0[0] = 1'b1;
        tick();
        checks++;
        if ({rsp_valid_0[0], rsp_valid_1[0], busy[0], alu_a[0], alu_b[0], alu_op[0],
             rsp_c[0], rsp_d[0], rsp_flags[0], psr_flags[0]} !== '0) begin
            errors++;
            $display("FAIL rst_exec_clear: got rv=%b%b busy=%b a=%h op=%h c=%h psr=%b, expected all 0",
                     rsp_valid_0[0], rsp_valid_1[0], busy[0], alu_a[0], alu_op[0], rsp_c[0], psr_flags[0]);
        end
        reset[0] = 1'b0;
        #1;
        checks++;
        if ({req_ready_0[0], req_ready_1[0]} !== 2'b10) begin
            errors++;
            $display("FAIL rst_exec_grant: got ready0/1=%b%b, expected 10", req_ready_0[0], req_ready_1[0]);
        end
        clear_inputs(0);
    endtask

    // Random traffic against a transaction-level model: each port holds a
    // queue of ops; the model tracks only who owns the ALU, how many edges
    // have passed since acceptance, and the expected result of that op.
    task automatic test_random(input int k, input int n);
        req_t q0[$];
        req_t q1[$];
        int exec, done, eg, m_port, m_age;
        bit m_busy, m_last, ev, v0, v1, rdy;
        logic [34:0] m_exp;
        logic [2:0] m_psr;
        req_t r0, r1;
        exec = (k == 0) ? 1 : 3;
        do_reset(k);
        for (int i = 0; i < n; i++) begin
            q0.push_back({4'($urandom_range(15)), 16'($urandom), 16'($urandom)});
            q1.push_back({4'($urandom_range(15)), 16'($urandom), 16'($urandom)});
        end
        m_busy = 0; m_last = 1; m_port = 0; m_age = 0; m_exp = '0; m_psr = 3'd0; done = 0;
        for (int c = 0; c < 4000 && done < 2 * n; c++) begin
            v0 = (q0.size() > 0) && ($urandom_range(3) != 0);
            v1 = (q1.size() > 0) && ($urandom_range(3) != 0);
            r0 = (q0.size() > 0) ? q0[0] : req_t'({4'($urandom_range(15)), 16'($urandom), 16'($urandom)});
            r1 = (q1.size() > 0) ? q1[0] : req_t'({4'($urandom_range(15)), 16'($urandom), 16'($urandom)});
            drive_req(k, 0, v0, r0.op, r0.a, r0.b);
            drive_req(k, 1, v1, r1.op, r1.a, r1.b);
            rsp_ready_0[k] = 1'($urandom_range(1));
            rsp_ready_1[k] = 1'($urandom_range(1));
            #1;
            eg = -1;
            if (!m_busy) begin
                if (v0 && v1) eg = m_last ? 0 : 1;
                else if (v0)  eg = 0;
                else if (v1)  eg = 1;
            end
            checks++;
            if ({req_ready_1[k], req_ready_0[k]} !== {eg == 1, eg == 0}) begin
                errors++;
                $display("FAIL rnd%0d_grant c%0d: got ready1/0=%b%b, expected %b%b",
                         k, c, req_ready_1[k], req_ready_0[k], eg == 1, eg == 0);
            end
            checks++;
            if (busy[k] !== m_busy) begin
                errors++;
                $display("FAIL rnd%0d_busy c%0d: got %b, expected %b", k, c, busy[k], m_busy);
            end
            ev = m_busy && (m_age >= exec);
            checks++;
            if ({rsp_valid_1[k], rsp_valid_0[k]} !== {ev && m_port == 1, ev && m_port == 0}) begin
                errors++;
                $display("FAIL rnd%0d_rsp_valid c%0d: got %b%b, expected %b%b", k, c,
                         rsp_valid_1[k], rsp_valid_0[k], ev && m_port == 1, ev && m_port == 0);
            end
            if (ev) begin
                checks++;
                if ({rsp_d[k], rsp_c[k], rsp_flags[k]} !== m_exp) begin
                    errors++;
                    $display("FAIL rnd%0d_result c%0d: got d=%h c=%h f=%b, expected d=%h c=%h f=%b", k, c,
                             rsp_d[k], rsp_c[k], rsp_flags[k], m_exp[34:19], m_exp[18:3], m_exp[2:0]);
                end
            end
            checks++;
            if (psr_flags[k] !== m_psr) begin
                errors++;
                $display("FAIL rnd%0d_psr c%0d: got %b, expected %b", k, c, psr_flags[k], m_psr);
            end
            if (!m_busy) begin
                if (eg == 0) begin
                    m_exp = alu_fn(r0.op, r0.a, r0.b); void'(q0.pop_front());
                    m_busy = 1; m_port = 0; m_age = 0;
                end else if (eg == 1) begin
                    m_exp = alu_fn(r1.op, r1.a, r1.b); void'(q1.pop_front());
                    m_busy = 1; m_port = 1; m_age = 0;
                end
            end else if (ev) begin
                rdy = (m_port == 0) ? rsp_ready_0[k] : rsp_ready_1[k];
                if (rdy) begin
                    m_busy = 0; m_last = (m_port == 1); done++;
                end
            end else begin
                m_age++;
                if (m_age == exec) m_psr = m_exp[2:0];
            end
            tick();
        end
        clear_inputs(k);
        checks++;
        if (done != 2 * n) begin
            errors++;
            $display("FAIL rnd%0d_complete: got %0d responses, expected %0d", k, done, 2 * n);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1;
            clear_inputs(k);
        end
        tick();
        test_reset();
        test_single();
        test_tie();
        test_mul();
        test_backpressure();
        test_exec3();
        test_reset_exec();
        test_random(0, 40);
        test_random(1, 30);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Sequencer that time-shares the single combinational ALU between two requesters: the instruction-fetch/execute path (port 0) and the address/auxiliary path (port 1). It arbitrates round-robin, registers operands onto the ALU inputs and holds them for a fixed number of execute cycles. It then captures C/D/flags into result registers, returns them over a valid/ready response handshake, and keeps the architectural flag register (Low/Negative/Zero) up to date.

Parameters:
WIDTH, 16, operand/result width; matches ALU A/B/C/D.
EXEC_CYCLES, 1, cycles operands are held on the ALU before capture (1..15); raised for timing closure on MUL/FMUL.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
req_valid_0, req_valid_1  in  1 each  requester has an operation pending
req_ready_0, req_ready_1  out  1 each  request accepted this cycle
req_op_0, req_op_1  in  4 each  opcode, encoding from the shared opcode include
req_a_0, req_a_1, req_b_0, req_b_1  in  WIDTH each  operands
rsp_valid_0, rsp_valid_1  out  1 each  result available for that requester
rsp_ready_0, rsp_ready_1  in  1 each  requester consumes result
rsp_c, rsp_d  out  WIDTH each  captured ALU C and D, shared by both ports
rsp_flags  out  3  captured {Low, Negative, Zero} for this op
psr_flags  out  3  architectural flag register {Low, Negative, Zero}
alu_a, alu_b  out  WIDTH each  registered to ALU A/B
alu_op  out  4  registered to ALU Opcode
alu_c, alu_d  in  WIDTH each  from ALU C/D
alu_low, alu_neg, alu_zero  in  1 each  from ALU flags
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous): state=IDLE; alu_a, alu_b, alu_op, rsp_c, rsp_d, rsp_flags and psr_flags are 0; rsp_valid_* are 0; busy is 0; last_grant=1, so port 0 wins the first tie.
- req_ready_i is combinational and equals (state==IDLE) && grant_i. It is never high outside IDLE. At most one req_ready is high per cycle.
- Grant in IDLE:
  - Only one valid: that port wins.
  - Both valid: the port != last_grant wins.
  - Neither valid: no grant.
- IDLE: on handshake (valid & ready), latch op/a/b into alu_op/alu_a/alu_b, record the granted port, load exec counter with EXEC_CYCLES-1, and go to EXEC.
- EXEC: alu_* are held stable.
  - Counter > 0: decrement.
  - Counter == 0: capture alu_c into rsp_c, alu_d into rsp_d, and {alu_low, alu_neg, alu_zero} into rsp_flags and psr_flags in the same edge; go to RESP.
- RESP: rsp_valid of the granted port is high and the other is 0. rsp_c, rsp_d and rsp_flags are held stable.
  - On rsp_ready of the granted port: set last_grant to the granted port and go to IDLE.
  - rsp_ready on the non-granted port is ignored.
- Latency: handshake at edge T gives rsp_valid high from cycle T+EXEC_CYCLES+1. Minimum initiation interval is EXEC_CYCLES+2 cycles per op; a new request may be accepted the cycle after the response handshake.
- Request inputs are sampled only at the accept edge; changes afterwards have no effect.
- psr_flags changes only at the capture edge. It holds otherwise, including while idle.
- rsp_d passes alu_d unmodified; it is 0 for all ops except MUL.
- Unknown or default opcodes are sequenced normally; whatever the ALU returns is captured.
- Reset mid-operation (EXEC or RESP): the op is discarded, no response is issued, and all reset values apply on the next cycle.
- A requester that drops valid before ready is simply not granted; there is no error.

Test Plan:
- Single op, EXEC_CYCLES=1: port0 SUB a=5 b=5 at T -> req_ready_0 high at T; rsp_valid_0 high at T+2; rsp_c=0x0000, rsp_d=0, Zero=1; psr_flags Zero=1; busy is 1 from T+1 until the response handshake.
- Tie round-robin: both valid continuously with port0 ADD 1+2 and port1 ADD 0x7FFF+1 -> grants alternate 0,1,0. Responses in order: port0 rsp_c=0x0003; port1 rsp_c=0x8000 with Negative=1.
- MUL and D path: port1 MUL a=0x1234 b=0x0100 -> rsp_c=0x3400, rsp_d=0x0012, rsp_valid_1 only.
- Backpressure: hold rsp_ready_0=0 for 5 cycles after rsp_valid_0 -> rsp_c/flags stable, req_ready_* stay 0 and the pending port1 request waits. After the handshake, IDLE on the next cycle grants port1.
- EXEC_CYCLES=3: accept at T -> alu_a/alu_b/alu_op stable from T+1 to T+3; rsp_valid rises at T+4. Changing req_a_0 after T does not alter the result.
- Reset in EXEC: reset asserted the cycle after accept -> no rsp_valid; next cycle all outputs 0 and busy=0. With both valid, port0 is granted first after reset.
